// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage core: PC and pipeline register
// enables, wrong-path fetch tracking, saturating performance counters.
module pipeline_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_hazard,
  input  logic             branch_hazard,
  input  logic             if_stall_req,
  input  logic             mem_stall_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] load_bubbles
);

  typedef enum logic {
    S_RUN     = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   do_flush;
  logic   do_bubble;

  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Overlapping conditions resolved strictly by priority order.
  always_comb begin
    state_nxt     = state;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    do_flush      = 1'b0;
    do_bubble     = 1'b0;
    priority case (1'b1)
      reset: begin
        pc_en         = 1'b0;
        if_id_flush   = 1'b1;
        id_exe_flush  = 1'b1;
        exe_mem_flush = 1'b1;
        state_nxt     = S_RUN;
      end
      mem_stall_req: begin
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        id_exe_en  = 1'b0;
        exe_mem_en = 1'b0;
        mem_wb_en  = 1'b0;
      end
      branch_hazard: begin
        if_id_flush   = 1'b1;
        id_exe_flush  = 1'b1;
        exe_mem_flush = 1'b1;
        do_flush      = 1'b1;
        state_nxt     = if_stall_req ? S_DISCARD : S_RUN;
      end
      load_hazard: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_flush = 1'b1;
        do_bubble    = 1'b1;
        if (!if_stall_req) state_nxt = S_RUN;
      end
      if_stall_req: begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
      (state == S_DISCARD): begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        state_nxt   = S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      load_bubbles <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (do_flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
      if (do_bubble && load_bubbles != '1)
        load_bubbles <= load_bubbles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed-vector bench for pipeline_controller (CNT_W=4 so that
// counter saturation is reachable in a short run).
module tb_pipeline_controller;

  localparam int CNT_W = 4;

  // {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
  //  if_id_flush, id_exe_flush, exe_mem_flush}
  localparam logic [7:0] C_RUN = 8'b1_1111_000;
  localparam logic [7:0] C_RST = 8'b0_1111_111;
  localparam logic [7:0] C_FRZ = 8'b0_0000_000;
  localparam logic [7:0] C_BR  = 8'b1_1111_111;
  localparam logic [7:0] C_LD  = 8'b0_0111_010;
  localparam logic [7:0] C_BUB = 8'b0_1111_100;

  logic clk = 1'b0;
  logic reset, load_hazard, branch_hazard;
  logic if_stall_req, mem_stall_req;
  logic pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
  logic if_id_flush, id_exe_flush, exe_mem_flush;
  logic [CNT_W-1:0] stall_cycles, flush_count, load_bubbles;
  logic [7:0] ctrl;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  pipeline_controller #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_hazard   (load_hazard),
    .branch_hazard (branch_hazard),
    .if_stall_req  (if_stall_req),
    .mem_stall_req (mem_stall_req),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_exe_en     (id_exe_en),
    .exe_mem_en    (exe_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_exe_flush  (id_exe_flush),
    .exe_mem_flush (exe_mem_flush),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .load_bubbles  (load_bubbles)
  );

  assign ctrl = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                 if_id_flush, id_exe_flush, exe_mem_flush};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, check the combinational controls.
  task automatic step(input string tag, input logic r, input logic lh,
                      input logic bh, input logic ifs, input logic ms,
                      input logic [7:0] exp);
    @(negedge clk);
    reset         = r;
    load_hazard   = lh;
    branch_hazard = bh;
    if_stall_req  = ifs;
    mem_stall_req = ms;
    #1 chk(tag, {24'd0, ctrl}, {24'd0, exp});
  endtask

  task automatic cnts(input string tag, input int s, input int f,
                      input int l);
    chk({tag, ".stall"}, 32'(stall_cycles), s);
    chk({tag, ".flush"}, 32'(flush_count), f);
    chk({tag, ".lbub"},  32'(load_bubbles), l);
  endtask

  task automatic do_reset();
    step("rst0", 1, 0, 0, 0, 0, C_RST);
    step("rst1", 1, 0, 0, 0, 0, C_RST);
  endtask

  initial begin
    reset = 1; load_hazard = 0; branch_hazard = 0;
    if_stall_req = 0; mem_stall_req = 0;

    // Reset then idle
    do_reset();
    step("idle", 0, 0, 0, 0, 0, C_RUN);
    cnts("idle", 0, 0, 0);
    step("idle2", 0, 0, 0, 0, 0, C_RUN);
    cnts("idle2", 0, 0, 0);

    // Single-cycle load-use
    step("ld", 0, 1, 0, 0, 0, C_LD);
    step("ld_after", 0, 0, 0, 0, 0, C_RUN);
    cnts("ld", 1, 0, 1);

    // Branch with fetch done: no discard
    do_reset();
    step("br", 0, 0, 1, 0, 0, C_BR);
    step("br_after", 0, 0, 0, 0, 0, C_RUN);
    cnts("br", 0, 1, 0);

    // Branch during fetch wait
    do_reset();
    step("bw0", 0, 0, 0, 1, 0, C_BUB);
    step("bw1", 0, 0, 1, 1, 0, C_BR);
    step("bw2", 0, 0, 0, 1, 0, C_BUB);
    step("bw3", 0, 0, 0, 1, 0, C_BUB);
    step("bw4_squash", 0, 0, 0, 0, 0, C_BUB);
    step("bw5", 0, 0, 0, 0, 0, C_RUN);
    cnts("bw", 4, 1, 0);

    // Memory freeze masks hazards, branch wins on release
    do_reset();
    step("frz0", 0, 1, 1, 0, 1, C_FRZ);
    step("frz1", 0, 1, 1, 0, 1, C_FRZ);
    step("frz2", 0, 1, 1, 0, 1, C_FRZ);
    step("frz_rel", 0, 1, 1, 0, 0, C_BR);
    step("frz_run", 0, 0, 0, 0, 0, C_RUN);
    cnts("frz", 3, 1, 0);

    // Freeze holds a pending discard
    do_reset();
    step("fd_br", 0, 0, 1, 1, 0, C_BR);
    step("fd_frz", 0, 0, 0, 0, 1, C_FRZ);
    step("fd_squash", 0, 0, 0, 0, 0, C_BUB);
    step("fd_run", 0, 0, 0, 0, 0, C_RUN);

    // Back-to-back branches recompute discard
    do_reset();
    step("bb0", 0, 0, 1, 1, 0, C_BR);
    step("bb1", 0, 0, 1, 0, 0, C_BR);
    step("bb_run", 0, 0, 0, 0, 0, C_RUN);
    cnts("bb", 0, 2, 0);

    // Load hazard with fetch done clears a pending discard
    do_reset();
    step("ldd_br", 0, 0, 1, 1, 0, C_BR);
    step("ldd_ld", 0, 1, 0, 0, 0, C_LD);
    step("ldd_run", 0, 0, 0, 0, 0, C_RUN);
    cnts("ldd", 1, 1, 1);

    // Saturation: 20 load stall cycles on 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++)
      step("sat_ld", 0, 1, 0, 0, 0, C_LD);
    step("sat_run", 0, 0, 0, 0, 0, C_RUN);
    cnts("sat", 15, 0, 15);

    // Reset asserted while discard pending
    step("rd_br", 0, 0, 1, 1, 0, C_BR);
    step("rd_rst", 1, 0, 0, 1, 0, C_RST);
    step("rd_run", 0, 0, 0, 0, 0, C_RUN);
    cnts("rd", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the 5-stage core (IF, ID, EXE, MEM, WB). It consumes the per-cycle hazard indications from the hazard detector (`load_hazard`, `branch_hazard`) and the memory-side wait requests. From these it drives the PC enable and the per-pipeline-register enable/flush controls. It tracks wrong-path instruction fetches that are still in flight across a redirect, and keeps saturating performance counters for stall cycles, flushes and load bubbles.

## Interface
- `CNT_W`, default 32: width of each performance counter.

- `clk`, in, 1: core clock.
- `reset`, in, 1: reset. Synchronous, active-high.
- `load_hazard`, in, 1: load-use hazard between ID and EXE.
- `branch_hazard`, in, 1: taken branch/jump resolved in MEM (the redirect cycle).
- `if_stall_req`, in, 1: instruction fetch not complete. Low means the fetch response is valid this cycle.
- `mem_stall_req`, in, 1: data access in MEM not complete.
- `pc_en`, out, 1: PC register load enable.
- `if_id_en`, `id_exe_en`, `exe_mem_en`, `mem_wb_en`, out, 1 each: pipeline register enables.
- `if_id_flush`, `id_exe_flush`, `exe_mem_flush`, out, 1 each: load a bubble (NOP) into that register. Each flush is qualified by its register's enable.
- `stall_cycles`, out, CNT_W: count of cycles with `pc_en`=0.
- `flush_count`, out, CNT_W: count of branch-flush cycles.
- `load_bubbles`, out, CNT_W: count of load-use bubbles inserted.

## Operation
- One state bit, `discard`: a fetch is outstanding for a wrong-path PC.
- Control outputs are combinational from the inputs, `discard` and `reset`. Counters are registered.
- Per-cycle priority, highest first:
  1. `reset`=1: all enables 1. `if_id_flush`, `id_exe_flush`, `exe_mem_flush` = 1. `pc_en`=0. `discard` cleared. Counters cleared.
  2. `mem_stall_req`=1 (full freeze):
     - `pc_en` and all four register enables = 0; all flushes = 0.
     - `branch_hazard` and `load_hazard` are ignored. MEM is frozen, so they re-present on release.
     - `discard` holds.
  3. `branch_hazard`=1:
     - `pc_en`=1 (target loaded); all enables = 1.
     - `if_id_flush`, `id_exe_flush`, `exe_mem_flush` = 1.
     - `discard` <= `if_stall_req`.
  4. `load_hazard`=1:
     - `pc_en`=0, `if_id_en`=0.
     - `id_exe_en`=1 with `id_exe_flush`=1 (bubble).
     - `exe_mem_en`=1, `mem_wb_en`=1.
     - If `if_stall_req`=0, `discard` clears.
  5. `if_stall_req`=1:
     - `pc_en`=0.
     - `if_id_en`=1 with `if_id_flush`=1.
     - Downstream enables = 1.
  6. `discard`=1 and `if_stall_req`=0 (stale response arrives):
     - `pc_en`=0 (target held; its fetch starts next cycle).
     - `if_id_en`=1 with `if_id_flush`=1; downstream enables = 1.
     - `discard` <= 0.
  7. Otherwise (run): `pc_en`=1; all enables = 1; all flushes = 0.
- Flushes not listed in a case are 0. Enables not listed in cases 2–6 are 1.
- Counters:
  - `stall_cycles` += 1 when `pc_en`=0 and `reset`=0.
  - `flush_count` += 1 on case 3.
  - `load_bubbles` += 1 on case 4.
  - All counters saturate at 2^CNT_W−1; no wrap.

## Timing
- Control outputs respond in the same cycle as their inputs (0-cycle latency). No register is in the enable path.
- Counters update on the rising edge after the qualifying cycle and are visible the next cycle.
- `discard` is set or cleared on the edge ending its cycle.
- A load-use stall lasts exactly as long as `load_hazard` stays high. With a 1-cycle `load_hazard`, exactly one bubble is inserted.
- Branch during an outstanding fetch:
  - The flush happens in the branch cycle.
  - Every following cycle with `if_stall_req`=1 inserts an IF/ID bubble.
  - The first cycle with `if_stall_req`=0 is squashed (case 6).
  - Only after that can a target-path instruction enter IF/ID.
- Branch with `if_stall_req`=0: `discard` stays 0. The fetched wrong-path instruction is removed by `if_id_flush` in the same cycle.
- Back-to-back branches: each cycle with `branch_hazard` flushes and recomputes `discard`.
- Reset asserted mid-stall or mid-discard: the next cycle is a clean reset state (case 1). No pending discard survives.

## Test plan
- Reset then idle: after 2 cycles of `reset`=1, release with all inputs 0 → `pc_en`=1, all enables 1, flushes 0, all counters 0.
- Load-use: `load_hazard`=1 for 1 cycle → that cycle `pc_en`=0, `if_id_en`=0, `id_exe_flush`=1; next cycle run. `load_bubbles`=1 and `stall_cycles`=1.
- Branch with fetch done: `branch_hazard`=1, `if_stall_req`=0 → `pc_en`=1, three flushes = 1, `discard` stays 0, `flush_count`=1.
- Branch during fetch wait: `if_stall_req` high for cycles 0–3, `branch_hazard` in cycle 1 → cycle 1 flushes. Cycles 2–3 each give an IF/ID bubble with `pc_en`=0. Cycle 4 (`if_stall_req`=0) squashes with `pc_en`=0 and `if_id_flush`=1. Cycle 5 runs.
- Memory freeze masks hazards: `mem_stall_req`=1 for 3 cycles with `branch_hazard`=1 and `load_hazard`=1 → all enables 0 and flushes 0 for 3 cycles. The release cycle performs the branch flush. `stall_cycles`=3, `flush_count`=1.
- Saturation and reset mid-discard: with CNT_W=4, 20 stall cycles → `stall_cycles`=15. Asserting `reset` while `discard`=1 → after release, `if_stall_req`=0 gives a run cycle, not a squash.
